// File: rtl/nec_ir_decoder_if.sv
// NEC IR decoder bus: raw receiver pin in, decoded word and event pulses out.
interface nec_ir_decoder_if;
  logic        ir_rx;
  logic [31:0] ir_command;
  logic        ir_data_ready;
  logic        ir_repeat;
  logic        frame_error;

  modport master (
    input  ir_rx,
    output ir_command,
    output ir_data_ready,
    output ir_repeat,
    output frame_error
  );

  modport slave (
    output ir_rx,
    input  ir_command,
    input  ir_data_ready,
    input  ir_repeat,
    input  frame_error
  );
endinterface

// File: rtl/nec_ir_decoder.sv
// NEC extended-address IR frame decoder with us edge timing.
// Define NEC_CHECK_EN to require command == ~inverted command.
module nec_ir_decoder #(
  parameter int CLKS_PER_US   = 50,
  parameter bit IR_ACTIVE_LOW = 1'b1
) (
  input logic             clk,
  input logic             reset,
  nec_ir_decoder_if.master bus
);

  localparam int   PW      = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic IDLE_LV = IR_ACTIVE_LOW;
  localparam logic [PW-1:0] P_LAST = PW'(CLKS_PER_US - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    CHECK,
    RPT_MARK
  } state_t;

  logic          s1_q, s2_q, prev_q;
  logic [PW-1:0] presc_q;
  logic [13:0]   dur_q;
  state_t        state_q;
  logic [5:0]    cnt_q;
  logic [31:0]   sh_q;
  logic [31:0]   cmd_q;
  logic          dr_q, rp_q, fe_q;

  logic edge_s;
  logic mark_s;
  logic chk_ok;
  logic tmo;

  assign edge_s = s2_q ^ prev_q;
  assign mark_s = s2_q ^ IDLE_LV;
  assign tmo    = (state_q != IDLE) && !edge_s
                  && (dur_q > 14'd12000);

`ifdef NEC_CHECK_EN
  assign chk_ok = (sh_q[31:24] == ~sh_q[23:16]);
`else
  assign chk_ok = 1'b1;
`endif

  function automatic logic win(
    input logic [13:0] d,
    input logic [13:0] lo,
    input logic [13:0] hi
  );
    return (d >= lo) && (d <= hi);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= IDLE_LV;
      s2_q   <= IDLE_LV;
      prev_q <= IDLE_LV;
    end else begin
      s1_q   <= bus.ir_rx;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // dur counts whole microseconds since the last edge
  always_ff @(posedge clk) begin
    if (reset || edge_s) begin
      presc_q <= '0;
      dur_q   <= '0;
    end else if (presc_q == P_LAST) begin
      presc_q <= '0;
      if (dur_q != 14'h3FFF)
        dur_q <= dur_q + 14'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      cmd_q   <= '0;
      dr_q    <= 1'b0;
      rp_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      dr_q <= 1'b0;
      rp_q <= 1'b0;
      fe_q <= 1'b0;
      if (tmo) begin
        fe_q    <= 1'b1;
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (edge_s && mark_s)
              state_q <= LEAD_MARK;
          end
          LEAD_MARK: begin
            if (edge_s) begin
              if (win(dur_q, 14'd8000, 14'd10000)) begin
                state_q <= LEAD_SPACE;
              end else begin
                fe_q    <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          LEAD_SPACE: begin
            if (edge_s) begin
              if (win(dur_q, 14'd4000, 14'd5000)) begin
                cnt_q   <= '0;
                state_q <= BIT_MARK;
              end else if (win(dur_q, 14'd2000, 14'd2500)) begin
                state_q <= RPT_MARK;
              end else begin
                fe_q    <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          BIT_MARK: begin
            if (edge_s) begin
              if (!win(dur_q, 14'd400, 14'd700)) begin
                fe_q    <= 1'b1;
                state_q <= IDLE;
              end else if (cnt_q == 6'd32) begin
                state_q <= CHECK;
              end else begin
                state_q <= BIT_SPACE;
              end
            end
          end
          BIT_SPACE: begin
            if (edge_s) begin
              if (win(dur_q, 14'd400, 14'd700)) begin
                sh_q    <= {1'b0, sh_q[31:1]};
                cnt_q   <= cnt_q + 6'd1;
                state_q <= BIT_MARK;
              end else if (win(dur_q, 14'd1400, 14'd1900)) begin
                sh_q    <= {1'b1, sh_q[31:1]};
                cnt_q   <= cnt_q + 6'd1;
                state_q <= BIT_MARK;
              end else begin
                fe_q    <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          CHECK: begin
            state_q <= IDLE;
            if (chk_ok) begin
              cmd_q <= sh_q;
              dr_q  <= 1'b1;
            end else begin
              fe_q  <= 1'b1;
            end
          end
          RPT_MARK: begin
            if (edge_s) begin
              if (win(dur_q, 14'd400, 14'd700))
                rp_q <= 1'b1;
              else
                fe_q <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ir_command    = cmd_q;
  assign bus.ir_data_ready = dr_q;
  assign bus.ir_repeat     = rp_q;
  assign bus.frame_error   = fe_q;

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed + randomized NEC frame bench for nec_ir_decoder.
module tb_nec_ir_decoder;
  localparam int C = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  nec_ir_decoder_if bus ();

  nec_ir_decoder #(
    .CLKS_PER_US  (C),
    .IR_ACTIVE_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_dr = 0, n_rp = 0, n_fe = 0, n_excl = 0;
  int dr_cyc = 0, fe_cyc = 0;
  int b_dr, b_rp, b_fe;
  int n_chk = 0, n_pass = 0;
  int last_edge = 0, stop_cyc = 0;
  logic [31:0] exp_cmd = '0;

  always @(negedge clk) begin
    if (bus.ir_data_ready) begin n_dr++; dr_cyc = cyc; end
    if (bus.ir_repeat) n_rp++;
    if (bus.frame_error) begin n_fe++; fe_cyc = cyc; end
    if (int'(bus.ir_data_ready) + int'(bus.ir_repeat)
        + int'(bus.frame_error) > 1) n_excl++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic int jit();
    return int'($urandom_range(0, 160)) - 80;
  endfunction

  // reference acceptance rule for a timing-valid frame
  function automatic bit accept(input logic [31:0] w);
`ifdef NEC_CHECK_EN
    return w[31:24] == ~w[23:16];
`else
    return 1'b1;
`endif
  endfunction

  task automatic hold(input logic lvl, input int us);
    bus.ir_rx = lvl;
    last_edge = cyc;
    repeat (us * C) @(negedge clk);
  endtask

  task automatic snap();
    b_dr = n_dr; b_rp = n_rp; b_fe = n_fe;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b0, 560 + jit());
      hold(1'b1, (w[i] ? 1690 : 560) + jit());
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    hold(1'b0, 9000 + jit());
    hold(1'b1, 4500 + jit());
    send_bits(w, 32);
    hold(1'b0, 560 + jit());
    hold(1'b1, 3000);
    stop_cyc = last_edge;
  endtask

  task automatic good_frame(input string tag, input logic [31:0] w);
    snap();
    send_frame(w);
    if (accept(w)) exp_cmd = w;
    check({tag, "_dr"}, n_dr - b_dr, accept(w) ? 1 : 0);
    check({tag, "_fe"}, n_fe - b_fe, accept(w) ? 0 : 1);
    check({tag, "_cmd"}, bus.ir_command, exp_cmd);
  endtask

  initial begin
    int lat;
    logic [7:0]  c8;
    logic [15:0] a16;
    bus.ir_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd", bus.ir_command, 32'h0);
    check("rst_dr", bus.ir_data_ready, 1'b0);
    check("rst_rp", bus.ir_repeat, 1'b0);
    check("rst_fe", bus.frame_error, 1'b0);
    reset = 1'b0;
    repeat (100) @(negedge clk);

    good_frame("f1", 32'hE9166B86);
    check("f1_lat", dr_cyc - stop_cyc, 4);

    snap();
    hold(1'b0, 9000); hold(1'b1, 2250);
    hold(1'b0, 560);  hold(1'b1, 3000);
    check("rpt_rp", n_rp - b_rp, 1);
    check("rpt_dr", n_dr - b_dr, 0);
    check("rpt_cmd", bus.ir_command, exp_cmd);

    good_frame("badchk", 32'hE9176B86);

    snap();
    hold(1'b0, 7000); hold(1'b1, 3000);
    check("short_fe", n_fe - b_fe, 1);
    check("short_cmd", bus.ir_command, exp_cmd);
    good_frame("f3", 32'hF30C6B86);

    snap();
    hold(1'b0, 9000); hold(1'b1, 4500);
    send_bits(32'h5A5A5A5A, 15);
    hold(1'b0, 560);
    hold(1'b1, 15000);
    lat = fe_cyc - last_edge;
    check("tmo_fe", n_fe - b_fe, 1);
    check("tmo_lat", (lat >= 12000 * C && lat <= 12002 * C + 4),
          1'b1);
    check("tmo_dr", n_dr - b_dr, 0);
    good_frame("f4", 32'hED126B86);

    snap();
    hold(1'b0, 9000); hold(1'b1, 4500);
    send_bits(32'hFFFF0000, 19);
    hold(1'b0, 560);
    bus.ir_rx = 1'b1;
    repeat (100 * C) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cmd = '0;
    repeat (2000 * C) @(negedge clk);
    check("mrst_pulses", (n_dr - b_dr) + (n_rp - b_rp) + (n_fe - b_fe), 0);
    check("mrst_cmd", bus.ir_command, 32'h0);

    for (int k = 0; k < 3; k++) begin
      c8  = 8'($urandom);
      a16 = 16'($urandom);
      good_frame("rnd", {~c8, c8, a16});
      check("rnd_lat", dr_cyc - stop_cyc, 4);
    end

    check("excl", n_excl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
